// File: rtl/wb_ram_arbiter.sv
// Round-robin Wishbone B3 arbiter sharing one RAM slave between MASTERS masters.
// Define WB_ARB_WATCHDOG_EN to add a stalled-access watchdog that terminates with err.
module wb_ram_arbiter #(
  parameter int MASTERS    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 256,
  localparam int SEL_WIDTH = DATA_WIDTH / 8
) (
  input  logic                          clk,
  input  logic                          rst_sys_n,
  input  logic [MASTERS*ADDR_WIDTH-1:0] m_adr_i,
  input  logic [MASTERS*DATA_WIDTH-1:0] m_dat_i,
  input  logic [MASTERS*SEL_WIDTH-1:0]  m_sel_i,
  input  logic [MASTERS-1:0]            m_cyc_i,
  input  logic [MASTERS-1:0]            m_stb_i,
  input  logic [MASTERS-1:0]            m_we_i,
  input  logic [3*MASTERS-1:0]          m_cti_i,
  input  logic [2*MASTERS-1:0]          m_bte_i,
  output logic [MASTERS*DATA_WIDTH-1:0] m_dat_o,
  output logic [MASTERS-1:0]            m_ack_o,
  output logic [MASTERS-1:0]            m_err_o,
  output logic [MASTERS-1:0]            m_rty_o,
  output logic [ADDR_WIDTH-1:0]         s_adr_o,
  output logic [DATA_WIDTH-1:0]         s_dat_o,
  output logic [SEL_WIDTH-1:0]          s_sel_o,
  output logic                          s_we_o,
  output logic [2:0]                    s_cti_o,
  output logic [1:0]                    s_bte_o,
  output logic                          s_cyc_o,
  output logic                          s_stb_o,
  input  logic [DATA_WIDTH-1:0]         s_dat_i,
  input  logic                          s_ack_i,
  input  logic                          s_err_i,
  input  logic                          s_rty_i,
  output logic [MASTERS-1:0]            grant_o,
  output logic                          busy_o
);

  localparam int PTR_W = $clog2(MASTERS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   gidx_q, gidx_d;
  logic [MASTERS-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   next_ptr_s;
  logic               win_found_s;
  logic [PTR_W-1:0]   win_idx_s;
  logic [PTR_W:0]     cand_sum_s;

  logic [ADDR_WIDTH-1:0] sel_adr_s;
  logic [DATA_WIDTH-1:0] sel_dat_s;
  logic [SEL_WIDTH-1:0]  sel_sel_s;
  logic [2:0]            sel_cti_s;
  logic [1:0]            sel_bte_s;
  logic                  sel_cyc_s;
  logic                  sel_stb_s;
  logic                  sel_we_s;

`ifdef WB_ARB_WATCHDOG_EN
  localparam int WDOG_W = $clog2(TIMEOUT) + 1;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              stall_s;
`endif

  // State, grant, priority pointer and watchdog registers.
  always_ff @(posedge clk or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_q  <= ST_IDLE;
      gidx_q   <= '0;
      grant_q  <= '0;
      rr_ptr_q <= '0;
`ifdef WB_ARB_WATCHDOG_EN
      wdog_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      gidx_q   <= gidx_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
`ifdef WB_ARB_WATCHDOG_EN
      wdog_q   <= wdog_d;
`endif
    end
  end

  // Round-robin search: first requesting master at or above rr_ptr, wrapping.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand_sum_s  = '0;
    for (int i = 0; i < MASTERS; i++) begin
      cand_sum_s = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
      if (cand_sum_s >= (PTR_W+1)'(MASTERS)) begin
        cand_sum_s = cand_sum_s - (PTR_W+1)'(MASTERS);
      end else begin
        cand_sum_s = cand_sum_s;
      end
      if (!win_found_s && m_cyc_i[cand_sum_s[PTR_W-1:0]]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_sum_s[PTR_W-1:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // AND-OR mux of the granted master's bus signals.
  always_comb begin
    sel_adr_s = '0;
    sel_dat_s = '0;
    sel_sel_s = '0;
    sel_cti_s = 3'b000;
    sel_bte_s = 2'b00;
    sel_cyc_s = 1'b0;
    sel_stb_s = 1'b0;
    sel_we_s  = 1'b0;
    for (int m = 0; m < MASTERS; m++) begin
      sel_adr_s = sel_adr_s | (m_adr_i[m*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{gidx_q == PTR_W'(m)}});
      sel_dat_s = sel_dat_s | (m_dat_i[m*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{gidx_q == PTR_W'(m)}});
      sel_sel_s = sel_sel_s | (m_sel_i[m*SEL_WIDTH +: SEL_WIDTH] & {SEL_WIDTH{gidx_q == PTR_W'(m)}});
      sel_cti_s = sel_cti_s | (m_cti_i[m*3 +: 3] & {3{gidx_q == PTR_W'(m)}});
      sel_bte_s = sel_bte_s | (m_bte_i[m*2 +: 2] & {2{gidx_q == PTR_W'(m)}});
      sel_cyc_s = sel_cyc_s | (m_cyc_i[m] & (gidx_q == PTR_W'(m)));
      sel_stb_s = sel_stb_s | (m_stb_i[m] & (gidx_q == PTR_W'(m)));
      sel_we_s  = sel_we_s  | (m_we_i[m]  & (gidx_q == PTR_W'(m)));
    end
  end

  assign next_ptr_s = (int'(gidx_q) == MASTERS - 1) ? '0 : gidx_q + PTR_W'(1);

`ifdef WB_ARB_WATCHDOG_EN
  assign stall_s = sel_stb_s & ~s_ack_i & ~s_err_i & ~s_rty_i;
`endif

  // Next-state logic and the zero-latency slave/master routing.
  always_comb begin
    state_d  = state_q;
    gidx_d   = gidx_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
`ifdef WB_ARB_WATCHDOG_EN
    wdog_d   = '0;
`endif
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_cti_o  = 3'b000;
    s_bte_o  = 2'b00;
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    m_ack_o  = '0;
    m_err_o  = '0;
    m_rty_o  = '0;
    case (state_q)
      ST_IDLE: begin
        if (win_found_s) begin
          state_d = ST_BUSY;
          gidx_d  = win_idx_s;
          grant_d = MASTERS'(1) << win_idx_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        s_adr_o = sel_adr_s;
        s_dat_o = sel_dat_s;
        s_sel_o = sel_sel_s;
        s_cti_o = sel_cti_s;
        s_bte_o = sel_bte_s;
        s_we_o  = sel_we_s;
        s_cyc_o = sel_cyc_s;
        s_stb_o = sel_stb_s;
        m_ack_o[gidx_q] = s_ack_i;
        m_err_o[gidx_q] = s_err_i;
        m_rty_o[gidx_q] = s_rty_i;
        if (!sel_cyc_s) begin
          state_d  = ST_IDLE;
          grant_d  = '0;
          rr_ptr_d = next_ptr_s;
`ifdef WB_ARB_WATCHDOG_EN
        end else if (stall_s) begin
          // Stall counted up to TIMEOUT-1; one more stalled cycle forces ERR.
          if (wdog_q == WDOG_W'(TIMEOUT - 1)) begin
            state_d = ST_ERR;
            wdog_d  = '0;
          end else begin
            wdog_d  = wdog_q + WDOG_W'(1);
          end
`endif
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_ERR: begin
        m_err_o[gidx_q] = 1'b1;
        state_d  = ST_IDLE;
        grant_d  = '0;
        rr_ptr_d = next_ptr_s;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  assign m_dat_o = {MASTERS{s_dat_i}};
  assign grant_o = grant_q;
  assign busy_o  = (state_q != ST_IDLE);

endmodule
